io_register_bank: RTL and testbench



---
 rtl/io_register_bank_pkg.sv | 33 +++
 rtl/io_register_bank_debouncer.sv | 48 ++++
 rtl/io_register_bank.sv | 115 +++++++++++
 tb/tb_io_register_bank.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_register_bank_pkg.sv
// Shared constants for the memory-mapped I/O register bank:
// register offsets, hex segment table and a constant clog2.
package io_register_bank_pkg;

    localparam int LED_OFS   = 0;
    localparam int DIGIT_OFS = 1;

    function automatic int btn_level_ofs_fn(input int num_digits);
        return num_digits + 1;
    endfunction

    function automatic int btn_press_ofs(input int num_digits);
        return num_digits + 2;
    endfunction

    // Active-low segments, bit 0 = segment a.
    localparam logic [0:15][6:0] HEX_SEG = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(value)) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/io_register_bank_debouncer.sv
// Two-flop synchroniser plus counter debouncer for one button;
// pressed pulses on the edge where the stable level rises.
module button_debouncer
    import io_register_bank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button,
    output logic level,
    output logic pressed
);

    localparam int CW = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] count_q;
    logic          level_q;
    logic          sample;
    logic          done;

    assign sample = sync_q[1];
    assign done   = (count_q == C_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            count_q <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], button};
            if (sample == level_q) begin
                count_q <= '0;
            end else if (done) begin
                level_q <= sample;
                count_q <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign level   = level_q;
    assign pressed = sample & ~level_q & done;

endmodule

// File: rtl/io_register_bank.sv
// LED / 7-segment / button register bank on the ulisp register port.
// IO_REGISTER_BANK_HEX_DECODE_EN: digits store nibbles, outputs hex-decoded.
module io_register_bank
    import io_register_bank_pkg::*;
#(
    parameter int BASE_INDEX      = 1,
    parameter int LED_WIDTH       = 8,
    parameter int NUM_DIGITS      = 4,
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              register_index,
    input  logic                    register_read,
    input  logic                    register_write,
    input  logic [15:0]             register_write_value,
    output logic [15:0]             register_read_value,
    output logic [LED_WIDTH-1:0]    led,
    output logic [7*NUM_DIGITS-1:0] digits,
    input  logic [NUM_BUTTONS-1:0]  buttons
);

`ifdef IO_REGISTER_BANK_HEX_DECODE_EN
    localparam int DW = 4;
`else
    localparam int DW = 7;
`endif

    localparam logic [7:0] LEVEL_OFS = 8'(btn_level_ofs_fn(NUM_DIGITS));
    localparam logic [7:0] PRESS_OFS = 8'(btn_press_ofs(NUM_DIGITS));

    logic [LED_WIDTH-1:0]   led_q;
    logic [DW-1:0]          digit_q [NUM_DIGITS];
    logic [NUM_BUTTONS-1:0] level;
    logic [NUM_BUTTONS-1:0] pressed;
    logic [NUM_BUTTONS-1:0] press_q;
    logic [7:0]             ofs;
    logic                   mapped;
    logic                   press_clr;
    logic [15:0]            rdata;
    logic                   unused_wdata;

    assign unused_wdata = ^register_write_value;

    // Indices below the base wrap negative and set ofs[7].
    assign ofs    = {1'b0, register_index} - 8'(BASE_INDEX);
    assign mapped = ~ofs[7];

    assign press_clr = register_read & mapped & (ofs == PRESS_OFS);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .button (buttons[i]),
            .level  (level[i]),
            .pressed(pressed[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) digit_q[k] <= '0;
        end else if (register_write && mapped) begin
            if (ofs == 8'(LED_OFS)) led_q <= register_write_value[LED_WIDTH-1:0];
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (ofs == 8'(DIGIT_OFS + k)) digit_q[k] <= register_write_value[DW-1:0];
            end
        end
    end

    // A rise on the clearing edge survives the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_q <= '0;
        end else begin
            press_q <= (press_q & ~{NUM_BUTTONS{press_clr}}) | pressed;
        end
    end

    always_comb begin
        rdata = '0;
        if (mapped) begin
            if (ofs == 8'(LED_OFS)) rdata[LED_WIDTH-1:0] = led_q;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (ofs == 8'(DIGIT_OFS + k)) rdata[DW-1:0] = digit_q[k];
            end
            if (ofs == LEVEL_OFS) rdata[NUM_BUTTONS-1:0] = level;
            if (ofs == PRESS_OFS) rdata[NUM_BUTTONS-1:0] = press_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            register_read_value <= '0;
        end else if (register_read) begin
            register_read_value <= rdata;
        end
    end

    assign led = led_q;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
`ifdef IO_REGISTER_BANK_HEX_DECODE_EN
        assign digits[7*k +: 7] = HEX_SEG[digit_q[k]];
`else
        assign digits[7*k +: 7] = digit_q[k];
`endif
    end

endmodule

// File: tb/tb_io_register_bank.sv
// Directed self-checking bench for io_register_bank (DEBOUNCE_CYCLES=4).
module tb_io_register_bank;

    logic        clk;
    logic        reset_n;
    logic [6:0]  register_index;
    logic        register_read;
    logic        register_write;
    logic [15:0] register_write_value;
    logic [15:0] register_read_value;
    logic [7:0]  led;
    logic [27:0] digits;
    logic [3:0]  buttons;

    int checks;
    int errors;

    io_register_bank #(
        .BASE_INDEX     (1),
        .LED_WIDTH      (8),
        .NUM_DIGITS     (4),
        .NUM_BUTTONS    (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .register_index      (register_index),
        .register_read       (register_read),
        .register_write      (register_write),
        .register_write_value(register_write_value),
        .register_read_value (register_read_value),
        .led                 (led),
        .digits              (digits),
        .buttons             (buttons)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IO_REGISTER_BANK_HEX_DECODE_EN
    localparam logic [27:0] DIGITS_RESET = {4{7'b1000000}};
`else
    localparam logic [27:0] DIGITS_RESET = 28'h0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [6:0] idx, input logic [15:0] val);
        register_index       = idx;
        register_write_value = val;
        register_write       = 1'b1;
        tick();
        register_write = 1'b0;
    endtask

    task automatic do_read(input logic [6:0] idx);
        register_index = idx;
        register_read  = 1'b1;
        tick();
        register_read = 1'b0;
    endtask

    task automatic test_reset();
        do_write(7'd1, 16'h00A5);
        do_write(7'd2, 16'h0009);
        do_read(7'd1);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL reset_led: got %h expected 00", led);
        end
        checks++;
        if (digits !== DIGITS_RESET) begin
            errors++;
            $display("FAIL reset_digits: got %h expected %h", digits, DIGITS_RESET);
        end
        checks++;
        if (register_read_value !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdv: got %h expected 0000", register_read_value);
        end
        #2 reset_n = 1'b1;
        tick();
        do_read(7'd6);
        checks++;
        if (register_read_value !== 16'h0000) begin
            errors++;
            $display("FAIL reset_level: got %h expected 0000", register_read_value);
        end
        do_read(7'd7);
        checks++;
        if (register_read_value !== 16'h0000) begin
            errors++;
            $display("FAIL reset_press: got %h expected 0000", register_read_value);
        end
    endtask

    task automatic test_write_read();
        logic [6:0]  exp_d1;
        logic [15:0] exp_r3;
`ifdef IO_REGISTER_BANK_HEX_DECODE_EN
        exp_d1 = 7'b0001110;
        exp_r3 = 16'h000F;
`else
        exp_d1 = 7'h7F;
        exp_r3 = 16'h007F;
`endif
        do_write(7'd1, 16'hABCD);
        do_write(7'd3, 16'h007F);
        checks++;
        if (led !== 8'hCD) begin
            errors++;
            $display("FAIL wr_led: got %h expected cd", led);
        end
        checks++;
        if (digits[13:7] !== exp_d1) begin
            errors++;
            $display("FAIL wr_digit1: got %h expected %h", digits[13:7], exp_d1);
        end
        do_read(7'd3);
        checks++;
        if (register_read_value !== exp_r3) begin
            errors++;
            $display("FAIL rd_digit1: got %h expected %h", register_read_value, exp_r3);
        end
        do_read(7'd9);
        checks++;
        if (register_read_value !== 16'h0000) begin
            errors++;
            $display("FAIL rd_unmapped9: got %h expected 0000", register_read_value);
        end
        do_read(7'd1);
        do_read(7'd0);
        checks++;
        if (register_read_value !== 16'h0000) begin
            errors++;
            $display("FAIL rd_unmapped0: got %h expected 0000", register_read_value);
        end
        do_write(7'd6, 16'h000F);
        do_read(7'd6);
        checks++;
        if (register_read_value !== 16'h0000) begin
            errors++;
            $display("FAIL wr_ro_level: got %h expected 0000", register_read_value);
        end
        // read and write the LED register in the same cycle
        register_index       = 7'd1;
        register_write_value = 16'h0055;
        register_write       = 1'b1;
        register_read        = 1'b1;
        tick();
        register_write = 1'b0;
        register_read  = 1'b0;
        checks++;
        if (register_read_value !== 16'h00CD) begin
            errors++;
            $display("FAIL rw_same_old: got %h expected 00cd", register_read_value);
        end
        checks++;
        if (led !== 8'h55) begin
            errors++;
            $display("FAIL rw_same_led: got %h expected 55", led);
        end
    endtask

    task automatic test_hex();
`ifdef IO_REGISTER_BANK_HEX_DECODE_EN
        do_write(7'd2, 16'h0003);
        checks++;
        if (digits[6:0] !== 7'b0110000) begin
            errors++;
            $display("FAIL hex_seg: got %b expected 0110000", digits[6:0]);
        end
        do_read(7'd2);
        checks++;
        if (register_read_value !== 16'h0003) begin
            errors++;
            $display("FAIL hex_read: got %h expected 0003", register_read_value);
        end
`else
        do_write(7'd2, 16'h00B3);
        checks++;
        if (digits[6:0] !== 7'h33) begin
            errors++;
            $display("FAIL raw_seg: got %h expected 33", digits[6:0]);
        end
        do_read(7'd5);
        do_read(7'd2);
        checks++;
        if (register_read_value !== 16'h0033) begin
            errors++;
            $display("FAIL raw_read: got %h expected 0033", register_read_value);
        end
`endif
    endtask

    task automatic test_debounce();
        logic [15:0] exp;
        buttons[2]     = 1'b1;
        register_index = 7'd6;
        register_read  = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp = (i >= 7) ? 16'h0004 : 16'h0000;
            checks++;
            if (register_read_value !== exp) begin
                errors++;
                $display("FAIL debounce_t%0d: got %h expected %h", i, register_read_value, exp);
            end
        end
        register_read  = 1'b0;
        register_index = 7'd0;
        tick();
        checks++;
        if (register_read_value !== 16'h0004) begin
            errors++;
            $display("FAIL read_hold: got %h expected 0004", register_read_value);
        end
        do_read(7'd7);
        checks++;
        if (register_read_value !== 16'h0004) begin
            errors++;
            $display("FAIL press_b2: got %h expected 0004", register_read_value);
        end
    endtask

    task automatic test_glitch();
        buttons[0] = 1'b1;
        tick();
        tick();
        tick();
        buttons[0]     = 1'b0;
        register_index = 7'd6;
        register_read  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (register_read_value !== 16'h0004) begin
                errors++;
                $display("FAIL glitch_t%0d: got %h expected 0004", i, register_read_value);
            end
        end
        register_read = 1'b0;
    endtask

    task automatic test_press_latch();
        for (int r = 0; r < 2; r++) begin
            buttons[1] = 1'b1;
            repeat (8) tick();
            buttons[1] = 1'b0;
            repeat (8) tick();
        end
        do_read(7'd7);
        checks++;
        if (register_read_value !== 16'h0002) begin
            errors++;
            $display("FAIL press_latch: got %h expected 0002", register_read_value);
        end
        do_read(7'd7);
        checks++;
        if (register_read_value !== 16'h0000) begin
            errors++;
            $display("FAIL press_cleared: got %h expected 0000", register_read_value);
        end
    endtask

    task automatic test_set_over_clear();
        buttons[3] = 1'b1;
        repeat (5) tick();
        do_read(7'd7);
        checks++;
        if (register_read_value !== 16'h0000) begin
            errors++;
            $display("FAIL soc_first: got %h expected 0000", register_read_value);
        end
        do_read(7'd7);
        checks++;
        if (register_read_value !== 16'h0008) begin
            errors++;
            $display("FAIL soc_second: got %h expected 0008", register_read_value);
        end
        do_read(7'd6);
        checks++;
        if (register_read_value !== 16'h000C) begin
            errors++;
            $display("FAIL soc_level: got %h expected 000c", register_read_value);
        end
    endtask

    task automatic test_reset_mid_debounce();
        buttons[0] = 1'b1;
        repeat (4) tick();
        #2 reset_n = 1'b0;
        buttons[0] = 1'b0;
        #2 reset_n = 1'b1;
        tick();
        do_read(7'd6);
        checks++;
        if (register_read_value !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset_level: got %h expected 0000", register_read_value);
        end
        repeat (8) tick();
        do_read(7'd6);
        checks++;
        if (register_read_value !== 16'h000C) begin
            errors++;
            $display("FAIL relevel: got %h expected 000c", register_read_value);
        end
        do_read(7'd7);
        checks++;
        if (register_read_value !== 16'h000C) begin
            errors++;
            $display("FAIL repress: got %h expected 000c", register_read_value);
        end
    endtask

    initial begin
        checks               = 0;
        errors               = 0;
        reset_n              = 1'b0;
        register_index       = 7'd0;
        register_read        = 1'b0;
        register_write       = 1'b0;
        register_write_value = 16'h0000;
        buttons              = 4'b0000;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        test_reset();
        test_write_read();
        test_hex();
        test_debounce();
        test_glitch();
        test_press_latch();
        test_set_over_clear();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
